// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

   localparam int XLEN_DEF  = 64;
   localparam int NREGS_DEF = 32;
   localparam logic [XLEN_DEF-1:0] REG_ZERO = '0;

   // Widest busy vector the counter helper accepts (NREGS up to 256)
   localparam int POP_W = 256;

   function automatic logic [8:0] popcount(input logic [POP_W-1:0] vec);
      logic [8:0] cnt;
      cnt = 9'd0;
      for (int i = 0; i < POP_W; i++) begin
         cnt = cnt + {8'd0, vec[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the register file: read ports, writeback, reserve, flush.
interface regfile_mp_if import regfile_pkg::*; #(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NREAD = 2
) ();

   localparam int AW = $clog2(NREGS);

   logic [NREAD*AW-1:0]   rd_addr;
   logic [NREAD*XLEN-1:0] rd_data;
   logic [NREAD-1:0]      rd_busy;
   logic                  wr_en;
   logic [AW-1:0]         wr_addr;
   logic [XLEN-1:0]       wr_data;
   logic                  rsv_en;
   logic [AW-1:0]         rsv_addr;
   logic                  flush;
   logic [AW:0]           busy_cnt;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
      input  rd_data, rd_busy, busy_cnt
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
      output rd_data, rd_busy, busy_cnt
   );

endinterface

// File: rtl/rf_busy_table.sv
// Per-register busy scoreboard: flush beats reserve, reserve beats release; x0 never busy.
module rf_busy_table import regfile_pkg::*; #(
   parameter  int NREGS = NREGS_DEF,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [AW-1:0]    set_addr,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_addr,
   input  logic             flush,
   output logic [NREGS-1:0] busy,
   output logic [AW:0]      busy_cnt
);

   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;
   logic [NREGS-1:0] w_set_mask;
   logic [NREGS-1:0] w_clr_mask;
   logic [AW:0]      r_cnt;

   // Decoded masks; applying set after clear lets a new producer win over a release
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      for (int i = 0; i < NREGS; i++) begin
         w_set_mask[i] = set_en && (set_addr == AW'(i)) && (i != 0);
         w_clr_mask[i] = clr_en && (clr_addr == AW'(i));
      end
      w_busy_nxt = flush ? '0 : ((r_busy & ~w_clr_mask) | w_set_mask);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_cnt  <= (AW+1)'(popcount(POP_W'(w_busy_nxt)));
      end
   end

   assign busy     = r_busy;
   assign busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file (x0 = 0) with busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding on the read ports.
module regfile_mp import regfile_pkg::*; #(
   parameter  int XLEN  = XLEN_DEF,
   parameter  int NREGS = NREGS_DEF,
   parameter  int NREAD = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic         clk,
   input  logic         rst,
   regfile_mp_if.slave  io_rf
);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] w_busy;
   logic             w_wr_live;

   assign w_wr_live = io_rf.wr_en && (io_rf.wr_addr != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_live) begin
         r_regs[io_rf.wr_addr] <= io_rf.wr_data;
      end
   end

   rf_busy_table #(.NREGS(NREGS)) u_busy (
      .clk      (clk),
      .rst      (rst),
      .set_en   (io_rf.rsv_en),
      .set_addr (io_rf.rsv_addr),
      .clr_en   (io_rf.wr_en),
      .clr_addr (io_rf.wr_addr),
      .flush    (io_rf.flush),
      .busy     (w_busy),
      .busy_cnt (io_rf.busy_cnt)
   );

   for (genvar p = 0; p < NREAD; p++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_data;
      logic            w_bsy;

      assign w_addr = io_rf.rd_addr[p*AW +: AW];

      // Read mux; reset forces zero so a forwarded write cannot leak out during rst
      always_comb begin
         w_data = r_regs[w_addr];
         w_bsy  = w_busy[w_addr];
         if (rst || (w_addr == '0)) begin
            w_data = XLEN'(REG_ZERO);
`ifdef REGFILE_BYPASS_EN
         end else if (w_wr_live && (io_rf.wr_addr == w_addr)) begin
            w_data = io_rf.wr_data;
`endif
         end else begin
            w_data = r_regs[w_addr];
         end
`ifdef REGFILE_BYPASS_EN
         if (w_wr_live && (io_rf.wr_addr == w_addr) &&
             !(io_rf.rsv_en && (io_rf.rsv_addr == w_addr))) begin
            w_bsy = 1'b0;
         end else begin
            w_bsy = w_busy[w_addr];
         end
`endif
      end

      assign io_rf.rd_data[p*XLEN +: XLEN] = w_data;
      assign io_rf.rd_busy[p]              = w_bsy;
   end

endmodule
